// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/decrement_unit.sv
// Combinational carry-lookahead x + all-ones (carry-in 0), i.e. x - 1 mod 2^WIDTH.
// c_out low means x was zero: the subtraction borrowed past the MSB.
module decrement_unit
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] out,
    output logic             c_out
);

    localparam logic [WIDTH-1:0] ADDEND = '1;

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = x & ADDEND;
    assign prop = x | ADDEND;

    // Each carry is expanded as an OR of generate terms gated by the propagates above them.
    always_comb begin
        logic term;
        carry = '0;
        term  = 1'b0;
        for (int i = 1; i <= WIDTH; i++) begin
            for (int j = 0; j < i; j++) begin
                term = gen[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & prop[k];
                end
                carry[i] = carry[i] | term;
            end
        end
    end

    assign out   = x ^ ADDEND ^ carry[WIDTH-1:0];
    assign c_out = carry[WIDTH];

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/hold, clocked on the falling edge of clk.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the last loaded value on each borrow.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             borrow_q;
    logic             dec_cout;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    decrement_unit #(.WIDTH(WIDTH)) u_dec (
        .x     (count_q),
        .out   (count_d),
        .c_out (dec_cout)
    );

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            borrow_q <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            borrow_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (load) begin
                        count_q <= load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        reload_q <= load_val;
`endif
                        state_q <= IDLE;
                    end else if (start && state_q == IDLE) begin
                        state_q <= (count_q != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (start) begin
                        state_q <= IDLE;
                    end else
`endif
                    if (pause) begin
                        state_q <= HOLD;
                    end else begin
                        count_q <= count_d;
                        if (count_q == WIDTH'(1)) begin
                            borrow_q <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_q != '0) begin
                                count_q <= reload_q;
                            end else begin
                                state_q <= DONE;
                            end
`else
                            state_q <= DONE;
`endif
                        end
                    end
                end
                HOLD: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (start) begin
                        state_q <= IDLE;
                    end else
`endif
                    if (!pause) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RUN is only ever entered with a non-zero count, so a decrement from zero is a design bug.
    assert property (@(negedge clk) disable iff (!reset_n)
                     (state_q == RUN && !pause) |-> dec_cout)
        else $error("countdown_timer: decrement from zero in RUN");

    assign count      = count_q;
    assign borrow_out = borrow_q;
    assign busy       = (state_q == RUN) || (state_q == HOLD);
    assign done       = (state_q == DONE);

endmodule
